// File: rtl/key_cmd_controller_pkg.sv
// Shared types and default key-bit positions for the key command controller.
// Imported by the controller RTL and by benches that probe its state.
package key_cmd_controller_pkg;

    // Two-bit state encoding; 2'b11 is never entered legally.
    typedef enum logic [1:0] {
        S_OFF  = 2'b00,
        S_ON   = 2'b01,
        S_MODE = 2'b10,
        S_ILL  = 2'b11
    } state_t;

    // Default positions of the request bits inside the 5-bit key.
    localparam int KEY_W        = 5;
    localparam int ON_BIT_DEF   = 0;
    localparam int MODE_BIT_DEF = 2;
    localparam int LOCK_BIT_DEF = 4;

    // Unit is powered in both legal "on" states.
    function automatic logic state_active(input state_t s);
        return (s == S_ON) || (s == S_MODE);
    endfunction

    function automatic logic state_mode(input state_t s);
        return (s == S_MODE);
    endfunction

endpackage

// File: rtl/key_cmd_controller.sv
// Moore FSM decoding a qualified 5-bit command key into Active / Mode.
// Ports: Clk, Reset (sync, active-high), InputKey[4:0], ValidCmd -> Active, Mode.
module key_cmd_controller
    import key_cmd_controller_pkg::*;
#(
    parameter int ON_BIT   = ON_BIT_DEF,
    parameter int MODE_BIT = MODE_BIT_DEF,
    parameter int LOCK_BIT = LOCK_BIT_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [KEY_W-1:0] InputKey,
    input  logic             ValidCmd,
    output logic             Active,
    output logic             Mode
);

    state_t cs;
    state_t ns;

    logic key_on;
    logic key_mode;
    logic key_lock;

    assign key_on   = InputKey[ON_BIT];
    assign key_mode = InputKey[MODE_BIT];
    assign key_lock = InputKey[LOCK_BIT];

    // Remaining key bits are don't-care.
    logic unused_key;
    assign unused_key = ^InputKey;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cs <= S_OFF;
        end else begin
            cs <= ns;
        end
    end

    always_comb begin
        ns = cs;
        unique case (cs)
            S_OFF: begin
                if (ValidCmd && key_on) begin
                    ns = key_mode ? S_MODE : S_ON;
                end
            end
            S_ON: begin
                if (ValidCmd) begin
                    if (!key_on) begin
                        ns = S_OFF;
                    end else if (!key_lock && key_mode) begin
                        ns = S_MODE;
                    end
                end
            end
            S_MODE: begin
                if (ValidCmd) begin
                    if (!key_on) begin
                        ns = S_OFF;
                    end else if (!key_lock && !key_mode) begin
                        ns = S_ON;
                    end
                end
            end
            // Recover from the unused encoding even without a command.
            S_ILL: begin
                ns = S_OFF;
            end
            default: begin
                ns = S_OFF;
            end
        endcase
    end

    // Outputs depend on cs only.
    always_comb begin
        Active = 1'b0;
        Mode   = 1'b0;
        Active = state_active(cs);
        Mode   = state_mode(cs);
    end

endmodule

// File: tb/tb_key_cmd_controller.sv
// Self-checking bench for key_cmd_controller against a rule-level model.
// Scenario tasks run in sequence; one summary line at the end.
module tb_key_cmd_controller;
    import key_cmd_controller_pkg::*;

    logic       Clk;
    logic       Reset;
    logic [4:0] InputKey;
    logic       ValidCmd;
    logic       Active;
    logic       Mode;

    int checks;
    int failures;
    int ms;

    key_cmd_controller dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .InputKey (InputKey),
        .ValidCmd (ValidCmd),
        .Active   (Active),
        .Mode     (Mode)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // 0=off 1=on 2=mode 3=illegal
    function automatic int nxt(int s, bit r, bit v, logic [4:0] k);
        if (r) return 0;
        if (s == 3) return 0;
        if (!v) return s;
        if (!k[0]) return 0;
        if (s == 0) return k[2] ? 2 : 1;
        if (k[4]) return s;
        return k[2] ? 2 : 1;
    endfunction

    function automatic logic [3:0] ev(int s);
        logic [1:0] sb;
        sb = s[1:0];
        return {sb, (s == 1 || s == 2), (s == 2)};
    endfunction

    task automatic apply(input bit r, input bit v, input logic [4:0] k);
        Reset    = r;
        ValidCmd = v;
        InputKey = k;
        @(posedge Clk);
        ms = nxt(ms, r, v, k);
        #1;
    endtask

    task automatic test_reset;
        logic [3:0] got;
        apply(1'b1, 1'b0, 5'b00000);
        got = {dut.cs, Active, Mode};
        checks++;
        if (got !== 4'b0000) begin
            failures++;
            $display("FAIL reset got=%b want=0000", got);
        end
    endtask

    task automatic test_held_mode;
        logic [3:0] got;
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b1, 5'b10101);
            got = {dut.cs, Active, Mode};
            checks++;
            if (got !== 4'b1011) begin
                failures++;
                $display("FAIL held_mode[%0d] got=%b want=1011", i, got);
            end
        end
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b0, 5'($urandom_range(0, 31)));
            got = {dut.cs, Active, Mode};
            checks++;
            if (got !== 4'b1011) begin
                failures++;
                $display("FAIL hold_invalid[%0d] got=%b want=1011", i, got);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [3:0] got;
        apply(1'b1, 1'b1, 5'b10101);
        got = {dut.cs, Active, Mode};
        checks++;
        if (got !== 4'b0000) begin
            failures++;
            $display("FAIL reset_mid got=%b want=0000", got);
        end
    endtask

    task automatic test_sequence;
        logic [4:0] keys [3];
        logic [3:0] want [3];
        logic [3:0] got;
        keys = '{5'b00001, 5'b00101, 5'b10000};
        want = '{4'b0110, 4'b1011, 4'b0000};
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b1, keys[i]);
            got = {dut.cs, Active, Mode};
            checks++;
            if (got !== want[i]) begin
                failures++;
                $display("FAIL seq[%0d] got=%b want=%b", i, got, want[i]);
            end
        end
    endtask

    task automatic test_lock;
        logic [4:0] keys [5];
        logic [3:0] want [5];
        logic [3:0] got;
        keys = '{5'b00001, 5'b10101, 5'b00101, 5'b10001, 5'b00001};
        want = '{4'b0110, 4'b0110, 4'b1011, 4'b1011, 4'b0110};
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b1, keys[i]);
            got = {dut.cs, Active, Mode};
            checks++;
            if (got !== want[i]) begin
                failures++;
                $display("FAIL lock[%0d] got=%b want=%b", i, got, want[i]);
            end
        end
    endtask

    task automatic test_illegal;
        logic [3:0] got;
        force dut.cs = state_t'(2'b11);
        #1;
        got = {dut.cs, Active, Mode};
        checks++;
        if (got !== 4'b1100) begin
            failures++;
            $display("FAIL illegal_out got=%b want=1100", got);
        end
        release dut.cs;
        ms = 3;
        apply(1'b0, 1'b0, 5'b10101);
        got = {dut.cs, Active, Mode};
        checks++;
        if (got !== 4'b0000) begin
            failures++;
            $display("FAIL illegal_recover got=%b want=0000", got);
        end
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 1'b0, (i % 2) ? 5'b11111 : 5'b00101);
            got = {dut.cs, Active, Mode};
            checks++;
            if (got !== 4'b0000) begin
                failures++;
                $display("FAIL invalid_toggle[%0d] got=%b want=0000", i, got);
            end
        end
    endtask

    task automatic test_random;
        logic [3:0] got;
        bit r;
        bit v;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 19) == 0);
            v = ($urandom_range(0, 3) != 0);
            apply(r, v, 5'($urandom_range(0, 31)));
            got = {dut.cs, Active, Mode};
            checks++;
            if (got !== ev(ms)) begin
                failures++;
                $display("FAIL rand[%0d] got=%b want=%b", i, got, ev(ms));
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        ms       = 0;
        Reset    = 1'b1;
        ValidCmd = 1'b0;
        InputKey = 5'b00000;
        test_reset();
        test_held_mode();
        test_reset_mid();
        test_sequence();
        test_lock();
        test_illegal();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
